// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature A/B front end for up_down_counter.
// Synchronises, glitch-filters and x4-decodes A/B; counts illegal jumps.
module quad_step_decoder #(
  parameter int FILT_LEN = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             en,
  input  logic             err_clr,
  output logic             step,
  output logic             up_down,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [7:0] LAST = 8'(FILT_LEN - 1);

  state_t     state, state_nxt;
  logic [1:0] init_cnt;
  logic       load;
  logic [1:0] sync1, sync2;
  logic [1:0] filt, prev;
  logic [7:0] cnt [2];
  logic [1:0] delta;
  logic       legal, illegal, dir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    unique case (state)
      INIT: begin
        if (init_cnt == 2'd2) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      init_cnt <= 2'd0;
    else if (state == INIT && init_cnt != 2'd2)
      init_cnt <= init_cnt + 2'd1;
  end

  // bit 1 = channel A, bit 0 = channel B
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {a_in, b_in};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt   <= 2'b00;
      cnt[0] <= 8'd0;
      cnt[1] <= 8'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (load) begin
          filt[i] <= sync2[i];
          cnt[i]  <= 8'd0;
        end else if (state != RUN || sync2[i] == filt[i]) begin
          cnt[i]  <= 8'd0;
        end else if (cnt[i] == LAST) begin
          filt[i] <= sync2[i];
          cnt[i]  <= 8'd0;
        end else begin
          cnt[i]  <= cnt[i] + 8'd1;
        end
      end
    end
  end

  assign delta   = filt ^ prev;
  assign legal   = (state == RUN) &&
                   (delta == 2'b01 || delta == 2'b10);
  assign illegal = (state == RUN) && (delta == 2'b11);
  // old A xor new B is 1 along 00->01->11->10->00
  assign dir     = prev[1] ^ filt[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev    <= 2'b00;
      step    <= 1'b0;
      err     <= 1'b0;
      up_down <= 1'b1;
      err_cnt <= '0;
    end else begin
      step <= legal && en;
      err  <= illegal;
      if (legal && en)
        up_down <= dir;
      if (load)
        prev <= sync2;
      else if (state == RUN)
        prev <= filt;
      if (err_clr)
        err_cnt <= '0;
      else if (illegal && err_cnt != '1)
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: directed + random stimulus vs a history-based
// model of the filtered levels and the Gray-code step rules.
module tb_quad_step_decoder;

  localparam int L    = 4;
  localparam int EW   = 8;
  localparam int CMAX = 255;
  localparam int MAXN = 16384;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_in = 1'b0;
  logic          b_in = 1'b0;
  logic          en = 1'b1;
  logic          err_clr = 1'b0;
  logic          step, up_down, err;
  logic [EW-1:0] err_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n      = 0;
  int n_step = 0;
  int n_err  = 0;
  int m_cnt  = 0;
  logic m_up = 1'b1;

  logic [1:0] xs [MAXN];
  logic [1:0] fv [MAXN];

  quad_step_decoder #(.FILT_LEN(L), .ERR_W(EW)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_in   (a_in),
    .b_in   (b_in),
    .en     (en),
    .err_clr(err_clr),
    .step   (step),
    .up_down(up_down),
    .err    (err),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)",
               tag, got, exp, n);
    end
  endtask

  function automatic int pos(logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  // one clock: drive inputs, advance model to edge n, compare
  task automatic cyc(logic [1:0] v, logic e, logic c);
    logic       es, ee, run;
    logic [1:0] cur, prv;
    {a_in, b_in} = v;
    en = e;
    err_clr = c;
    @(posedge clk);
    if (n >= MAXN - 1) begin
      $display("FAIL history: edge budget %0d exceeded", MAXN);
      $fatal(1, "history overflow");
    end
    n++;
    xs[n] = v;
    fv[n] = fv[n-1];
    if (n == 3) begin
      fv[n] = xs[1];
    end else if (n >= L + 3) begin
      for (int ch = 0; ch < 2; ch++) begin
        run = 1'b1;
        for (int k = 0; k < L; k++)
          if (xs[n-2-k][ch] == fv[n-1][ch]) run = 1'b0;
        if (run) fv[n][ch] = ~fv[n-1][ch];
      end
    end
    es = 1'b0;
    ee = 1'b0;
    if (n >= 5) begin
      cur = fv[n-1];
      prv = fv[n-2];
      if ((cur ^ prv) == 2'b11) begin
        ee = 1'b1;
      end else if (cur != prv && e) begin
        es = 1'b1;
        m_up = ((pos(cur) - pos(prv) + 4) % 4) == 1;
      end
    end
    if (c) m_cnt = 0;
    else if (ee && m_cnt < CMAX) m_cnt++;
    #1;
    chk("step", step, es);
    chk("err", err, ee);
    chk("up_down", up_down, m_up);
    chk("err_cnt", err_cnt, m_cnt);
    if (step) n_step++;
    if (err) n_err++;
  endtask

  task automatic seg(logic [1:0] v, int len, logic e, output int first);
    first = -1;
    for (int k = 0; k < len; k++) begin
      cyc(v, e, 1'b0);
      if (step && first < 0) first = k;
    end
  endtask

  task automatic do_reset(logic [1:0] v);
    #1;
    rst = 1'b0;
    {a_in, b_in} = v;
    en = 1'b1;
    err_clr = 1'b0;
    #1;
    chk("rst_step", step, 0);
    chk("rst_err", err, 0);
    chk("rst_dir", up_down, 1);
    chk("rst_cnt", err_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    n = 0;
    m_up = 1'b1;
    m_cnt = 0;
  endtask

  initial begin
    int f, s0, e0, len;
    logic ud0;
    logic [1:0] v;
    logic [1:0] up_seq [4];
    logic [1:0] dn_seq [4];
    up_seq = '{2'b01, 2'b11, 2'b10, 2'b00};
    dn_seq = '{2'b10, 2'b11, 2'b01, 2'b00};

    do_reset(2'b11);
    s0 = n_step;
    e0 = n_err;
    for (int k = 0; k < 10; k++) cyc(2'b11, 1'b1, 1'b0);
    chk("idle_steps", n_step - s0, 0);
    chk("idle_errs", n_err - e0, 0);
    chk("idle_dir", up_down, 1);
    chk("idle_cnt", err_cnt, 0);

    // mid-operation reset, restart from 00
    do_reset(2'b00);
    for (int k = 0; k < 10; k++) cyc(2'b00, 1'b1, 1'b0);

    s0 = n_step;
    for (int i = 0; i < 4; i++) begin
      seg(up_seq[i], 10, 1'b1, f);
      chk("up_latency", f, 6);
    end
    chk("up_steps", n_step - s0, 4);
    chk("up_dir", up_down, 1);

    s0 = n_step;
    for (int i = 0; i < 4; i++) begin
      seg(dn_seq[i], 10, 1'b1, f);
      chk("dn_latency", f, 6);
      if (i == 0) chk("dn_first_dir", up_down, 0);
    end
    chk("dn_steps", n_step - s0, 4);
    chk("dn_dir", up_down, 0);

    s0 = n_step;
    e0 = n_err;
    seg(2'b10, 3, 1'b1, f);
    seg(2'b00, 12, 1'b1, f);
    chk("glitch_steps", n_step - s0, 0);
    chk("glitch_errs", n_err - e0, 0);
    s0 = n_step;
    seg(2'b10, 4, 1'b1, f);
    seg(2'b00, 12, 1'b1, f);
    chk("pulse_steps", n_step - s0, 2);

    ud0 = up_down;
    s0 = n_step;
    e0 = n_err;
    seg(2'b11, 10, 1'b1, f);
    chk("jump_errs", n_err - e0, 1);
    chk("jump_cnt", err_cnt, 1);
    chk("jump_steps", n_step - s0, 0);
    chk("jump_dir", up_down, ud0);
    v = 2'b11;
    for (int i = 0; i < 299; i++) begin
      v = ~v;
      seg(v, 7, 1'b1, f);
    end
    chk("sat_cnt", err_cnt, CMAX);
    for (int k = 0; k < 10; k++)
      cyc(2'b11, 1'b1, k == 6);
    chk("clr_wins", err_cnt, 0);

    seg(2'b10, 10, 1'b1, f);
    seg(2'b00, 10, 1'b1, f);
    seg(2'b10, 10, 1'b1, f);
    chk("pre_en_dir", up_down, 0);
    s0 = n_step;
    seg(2'b00, 10, 1'b0, f);
    seg(2'b01, 10, 1'b0, f);
    chk("en0_steps", n_step - s0, 0);
    chk("en0_dir", up_down, 0);
    s0 = n_step;
    seg(2'b11, 10, 1'b1, f);
    chk("en1_steps", n_step - s0, 1);
    chk("en1_dir", up_down, 1);

    for (int i = 0; i < 300; i++) begin
      v = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 10);
      for (int k = 0; k < len; k++)
        cyc(v, $urandom_range(0, 7) != 0, $urandom_range(0, 99) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream front end for up_down_counter.
- Converts two asynchronous quadrature inputs (A/B from a rotary encoder or switch pair) into a one-cycle step pulse and a held direction level.
- step drives the counter's count enable; up_down drives its up_down input.
- Provides input synchronisation, per-channel glitch filtering, x4 Gray-code decoding and illegal-transition error counting.

Parameters:
FILT_LEN, 4, consecutive clk cycles a synchronised channel must differ from its filtered value before the filtered value updates; legal range 1..255.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset (asserted when 0).
a_in  input  1  quadrature channel A, asynchronous to clk.
b_in  input  1  quadrature channel B, asynchronous to clk.
en  input  1  synchronous enable; 0 suppresses step and direction updates.
err_clr  input  1  synchronous clear of err_cnt.
step  output  1  one-cycle pulse per legal quadrature edge.
up_down  output  1  direction of last legal step: 1 = up, 0 = down.
err  output  1  one-cycle pulse on an illegal transition (both channels changed).
err_cnt  output  ERR_W  saturating count of illegal transitions.

Behaviour:
- Reset (rst=0, async):
  - step=0, err=0, up_down=1, err_cnt=0.
  - Sync flops, filter counters and filtered values are cleared.
  - FSM goes to INIT.
- Synchroniser: a two-flop chain per channel (sync1, sync2); nothing downstream uses a_in or b_in directly.
- Filter, per channel, independent:
  - If sync2 equals filt, the mismatch counter clears to 0.
  - Otherwise the counter increments.
  - On the edge where the FILT_LEN-th consecutive mismatch is registered, filt takes sync2 and the counter clears.
  - A pulse shorter than FILT_LEN cycles never reaches filt.
- FSM INIT:
  - Waits 2 cycles after reset release.
  - Then loads filt and prev directly from sync2 (no filtering), emits no step and no err, and goes to RUN.
- FSM RUN: each cycle, compare filt {A,B} against prev {A,B}, then set prev to filt.
  - Up sequence (up_down=1): 00→01→11→10→00.
  - Down sequence (up_down=0): the reverse.
  - No change: no action.
  - One channel changed, en=1: step=1 next cycle; up_down is set to the decoded direction in the same edge as step.
  - One channel changed, en=0: step stays 0 and up_down is held.
  - Both channels changed: err=1 next cycle, no step, up_down is held, err_cnt increments (saturates at 2^ERR_W-1). This applies regardless of en.
- err_cnt clear:
  - err_clr=1 sets err_cnt to 0 on the next edge.
  - If err_clr and an error occur in the same cycle, clear wins and err_cnt=0.
- Latency: take edge 0 as the first edge that samples a new stable level.
  - filt updates at edge FILT_LEN+1.
  - step or err is high for the cycle after edge FILT_LEN+2, i.e. edge 6 for the default FILT_LEN.
- Timing rules:
  - step and err are never both high.
  - step is never high on two consecutive cycles unless two filtered transitions occur on consecutive cycles.
- Reset mid-operation: all state is lost immediately and the FSM re-enters INIT. The first post-reset input level produces no step.

Test Plan:
- Reset with a_in=b_in=1, release, hold for 10 cycles → step=0 and err=0 throughout; up_down=1; err_cnt=0.
- From AB=00, apply 01,11,10,00, each held 10 cycles, FILT_LEN=4 → exactly 4 step pulses, each 6 edges after the input change; up_down=1.
- Apply reverse sequence 00→10→11→01→00 → 4 steps; up_down drops to 0 in the same cycle as the first step.
- Apply a 3-cycle glitch on a_in (FILT_LEN=4) → no step, no err; then a 4-cycle pulse → 2 steps (out and back).
- Switch AB 00→11 in one cycle → err=1 for one cycle, err_cnt=1, no step, up_down unchanged; repeat 300 times → err_cnt=255; assert err_clr together with an error → err_cnt=0.
- Hold en=0 and apply 01 → no step, up_down held; raise en and apply 11 → one step with up_down=1.
